led_sequence_ctrl: RTL and testbench

Command-driven controller that sequences an LED bank through counting, rotating and blinking patterns at a programmable step period. It sits above the LED datapath in the blinking-LED designs. It accepts one pattern command at a time over a valid/ready handshake, runs it for a programmed number of steps or until aborted, and signals completion with a one-cycle pulse.

---
 rtl/led_sequence_ctrl.sv | 133 +++++++++++++
 tb/tb_led_sequence_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/led_sequence_ctrl.sv
// led_sequence_ctrl
//   Command-driven LED pattern sequencer. Accepts one command at a time
//   over a valid/ready handshake. It then steps the LED bank through a COUNT,
//   SHIFT (rotate-left) or BLINK pattern once every programmed period. The
//   command runs for a programmed number of steps, or until ABORT when the
//   step count is 0. DONE pulses for one cycle on normal completion. CLEAR
//   zeroes the LEDs and pulses DONE without leaving IDLE.
//
// Ports
//   CLK, RST    clock; synchronous active-high reset
//   CMD_VALID   command present             CMD_READY  controller idle
//   CMD_MODE    0 COUNT, 1 SHIFT, 2 BLINK, 3 CLEAR
//   CMD_PERIOD  clock cycles per step (0 treated as 1)
//   CMD_STEPS   steps to run (0 = until ABORT)
//   ABORT       stop a running command (ignored in IDLE)
//   LED         registered pattern output
//   BUSY        command running
//   DONE        registered one-cycle completion pulse
module led_sequence_ctrl #(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CMD_VALID,
  output logic                 CMD_READY,
  input  logic [1:0]           CMD_MODE,
  input  logic [DIV_WIDTH-1:0] CMD_PERIOD,
  input  logic [15:0]          CMD_STEPS,
  input  logic                 ABORT,
  output logic [WIDTH-1:0]     LED,
  output logic                 BUSY,
  output logic                 DONE
);

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [1:0] {
    MODE_COUNT = 2'd0,
    MODE_SHIFT = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_CLEAR = 2'd3
  } mode_t;

  state_t               state_q, state_d;
  mode_t                mode_q, mode_d;
  logic [DIV_WIDTH-1:0] period_q, period_d;
  logic [DIV_WIDTH-1:0] count_q, count_d;
  logic [15:0]          remain_q, remain_d;
  logic [WIDTH-1:0]     led_q, led_d;
  logic                 done_q, done_d;
  logic                 tick;

  // period_q is never 0 while in RUN, so period_q-1 cannot underflow there.
  assign tick = (count_q == period_q - DIV_WIDTH'(1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      mode_q   <= MODE_COUNT;
      period_q <= '0;
      count_q  <= '0;
      remain_q <= '0;
      led_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      count_q  <= count_d;
      remain_q <= remain_d;
      led_q    <= led_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    period_d  = period_q;
    count_d   = count_q;
    remain_d  = remain_q;
    led_d     = led_q;
    done_d    = 1'b0;
    CMD_READY = (state_q == IDLE);
    BUSY      = (state_q == RUN);

    case (state_q)
      IDLE: begin
        if (CMD_VALID) begin
          mode_d   = mode_t'(CMD_MODE);
          period_d = (CMD_PERIOD == '0) ? DIV_WIDTH'(1) : CMD_PERIOD;
          remain_d = CMD_STEPS;
          count_d  = '0;
          led_d    = (mode_t'(CMD_MODE) == MODE_SHIFT) ? WIDTH'(1) : '0;
          if (mode_t'(CMD_MODE) == MODE_CLEAR) done_d = 1'b1;
          else                                 state_d = RUN;
        end
      end

      RUN: begin
        if (ABORT) begin
          // Abort wins over a coincident tick: LED holds, no DONE.
          state_d = IDLE;
          count_d = '0;
        end else if (tick) begin
          count_d = '0;
          case (mode_q)
            MODE_COUNT: led_d = led_q + WIDTH'(1);
            MODE_SHIFT: led_d = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
            MODE_BLINK: led_d = ~led_q;
            default:    led_d = led_q;
          endcase
          // remain_q == 0 means run forever; never counted down.
          if (remain_q != '0) begin
            remain_d = remain_q - 16'd1;
            if (remain_q == 16'd1) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end else begin
          count_d = count_q + DIV_WIDTH'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign LED  = led_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_led_sequence_ctrl.sv
// Randomized + directed bench for led_sequence_ctrl. The driver applies
// inputs and advances a reference model after each edge. The reference model
// computes the LED value arithmetically from the number of elapsed steps
// since accept. It then queues the expected outputs. A separate monitor pops
// and compares them against the DUT each cycle.
module tb_led_sequence_ctrl;
  localparam int W = 8;

  logic         CLK;
  logic         rst, cmd_valid, cmd_ready, abort, busy, done;
  logic [1:0]   cmd_mode;
  logic [31:0]  cmd_period;
  logic [15:0]  cmd_steps;
  logic [W-1:0] led;

  led_sequence_ctrl #(.WIDTH(W), .DIV_WIDTH(32)) dut (
    .CLK(CLK), .RST(rst), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
    .CMD_MODE(cmd_mode), .CMD_PERIOD(cmd_period), .CMD_STEPS(cmd_steps),
    .ABORT(abort), .LED(led), .BUSY(busy), .DONE(done)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [W-1:0] led;
    bit           busy;
    bit           done;
    bit           ready;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  // Reference model state: the active command and the number of edges since accept
  bit           m_active = 0;
  bit           m_acc    = 0;
  int           m_mode, m_P, m_N, m_k;
  logic [W-1:0] m_led = '0;

  // LED value after s completed steps of a pattern.
  function automatic logic [W-1:0] pat(input int mode, input int s);
    logic [W-1:0] v;
    case (mode)
      0:       v = W'(s % (1 << W));
      1:       v = W'(1) << (s % W);
      2:       v = (s % 2 == 1) ? '1 : '0;
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic model(input bit r, input bit v, input int md, input int per,
                       input int st, input bit a);
    exp_t e;
    e.done = 0;
    m_acc  = 0;
    if (r) begin
      m_active = 0;
      m_led    = '0;
    end else if (!m_active) begin
      if (v) begin
        m_acc = 1;
        if (md == 3) begin
          m_led  = '0;
          e.done = 1;
        end else begin
          m_active = 1;
          m_mode   = md;
          m_P      = (per == 0) ? 1 : per;
          m_N      = st;
          m_k      = 0;
        end
      end
    end else if (a) begin
      m_led    = pat(m_mode, m_k / m_P);
      m_active = 0;
    end else begin
      m_k++;
      if (m_N != 0 && m_k == m_N * m_P) begin
        m_active = 0;
        m_led    = pat(m_mode, m_N);
        e.done   = 1;
      end
    end
    e.busy  = m_active;
    e.ready = !m_active;
    e.led   = m_active ? pat(m_mode, m_k / m_P) : m_led;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit r, input bit v, input int md, input int per,
                     input int st, input bit a);
    @(negedge CLK);
    rst        = r;
    cmd_valid  = v;
    cmd_mode   = 2'(md);
    cmd_period = 32'(per);
    cmd_steps  = 16'(st);
    abort      = a;
    @(posedge CLK);
    cycle++;
    model(r, v, md, per, st, a);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0);
  endtask

  // Holds the command until accepted. An endless command still running is
  // aborted first.
  task automatic issue(input int md, input int per, input int st);
    int n;
    n = 0;
    do begin
      cyc(0, 1, md, per, st, m_active && m_N == 0);
      n++;
    end while (!m_acc && n < 2000);
    if (!m_acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout mode=%0d waited=%0d cycles, required acceptance", md, n);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cycle, got, expv);
    end
  endtask

  // Monitor: samples 1 time unit after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("led",       32'(led),       32'(e.led));
        chk("busy",      32'(busy),      32'(e.busy));
        chk("done",      32'(done),      32'(e.done));
        chk("cmd_ready", 32'(cmd_ready), 32'(e.ready));
      end
    end
  end

  initial begin
    rst = 1; cmd_valid = 0; cmd_mode = 0; cmd_period = 0; cmd_steps = 0; abort = 0;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);

    issue(0, 4, 3);  idle(15);       // COUNT, period 4, 3 steps
    issue(1, 0, 9);  idle(12);       // SHIFT, period 0 -> 1, 9 steps
    issue(2, 3, 0);  idle(11);       // BLINK forever
    cyc(0, 0, 0, 0, 0, 1);           // abort on the edge that would tick
    idle(4);
    issue(0, 2, 2);                  // handshake: next command held during RUN
    issue(1, 1, 3);  idle(6);
    issue(0, 1, 256); idle(260);     // wrap 255 -> 0 on final step
    issue(3, 0, 0);  idle(3);        // CLEAR
    issue(2, 2, 0);  idle(5);        // reset mid-run
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    idle(2);

    for (int i = 0; i < 40; i++) begin
      int n;
      issue($urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 6));
      n = $urandom_range(0, 40);
      for (int j = 0; j < n; j++)
        cyc($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 6),
            $urandom_range(0, 15) == 0);
    end

    idle(2);
    @(posedge CLK);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
